// File: rtl/fix_rx_pkg.sv
// Shared constants and parser state encoding for the FIX receive framer.
package fix_rx_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_EQ = 8'h3D;

  typedef enum logic [2:0] {IDLE, BODY, T1, T0, CK0, CK1, CK2, END} parser_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/fix_tag_parser.sv
// Tracks FIX framing on the incoming byte stream and flags the end-of-message SOH and whether
// that message must be discarded; checksum compare only with FIX_RX_CHECKSUM_EN defined.
module fix_tag_parser
  import fix_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_i,
  input  logic [7:0] byte_i,
  input  logic       lost_i,
  output logic       eom_pulse_o,
  output logic       msg_bad_o
);

  parser_state_t state_q;
  logic          bad_q;
  logic          digit;

  assign digit       = is_digit(byte_i);
  assign eom_pulse_o = vld_i && (state_q == END) && (byte_i == SOH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bad_q   <= 1'b0;
    end else if (vld_i) begin
      // Lost bytes still walk the FSM so framing stays aligned with the sender.
      if (eom_pulse_o) begin
        bad_q <= 1'b0;
      end else if (lost_i) begin
        bad_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (byte_i == ASCII_1)  state_q <= T1;
          else if (byte_i == SOH) state_q <= IDLE;
          else                    state_q <= BODY;
        end
        BODY: state_q <= (byte_i == SOH) ? IDLE : BODY;
        T1: begin
          if (byte_i == ASCII_0)  state_q <= T0;
          else if (byte_i == SOH) state_q <= IDLE;
          else                    state_q <= BODY;
        end
        T0: begin
          if (byte_i == ASCII_EQ) state_q <= CK0;
          else if (byte_i == SOH) state_q <= IDLE;
          else                    state_q <= BODY;
        end
        CK0: begin
          if (digit) state_q <= CK1;
          else begin
            state_q <= BODY;
            bad_q   <= 1'b1;
          end
        end
        CK1: begin
          if (digit) state_q <= CK2;
          else begin
            state_q <= BODY;
            bad_q   <= 1'b1;
          end
        end
        CK2: begin
          if (digit) state_q <= END;
          else begin
            state_q <= BODY;
            bad_q   <= 1'b1;
          end
        end
        END: begin
          if (byte_i == SOH) state_q <= IDLE;
          else begin
            state_q <= BODY;
            bad_q   <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FIX_RX_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_soh_q;
  logic [7:0] sum_inc;
  logic [9:0] ck_q;
  logic [9:0] digit_val;

  assign sum_inc   = sum_q + byte_i;
  assign digit_val = {6'b0, byte_i[3:0]};

  // sum_soh holds the sum up to the SOH preceding the "10=" tag; it is frozen inside the trailer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= 8'd0;
      sum_soh_q <= 8'd0;
      ck_q      <= 10'd0;
    end else if (vld_i) begin
      if (eom_pulse_o) begin
        sum_q     <= 8'd0;
        sum_soh_q <= 8'd0;
        ck_q      <= 10'd0;
      end else begin
        sum_q <= sum_inc;
        if ((byte_i == SOH) && ((state_q == IDLE) || (state_q == BODY))) begin
          sum_soh_q <= sum_inc;
        end
        if (digit) begin
          if (state_q == CK0) begin
            ck_q <= digit_val;
          end else if ((state_q == CK1) || (state_q == CK2)) begin
            ck_q <= ck_q * 10'd10 + digit_val;
          end
        end
      end
    end
  end

  assign msg_bad_o = bad_q || lost_i || (ck_q != {2'b00, sum_soh_q});
`else
  assign msg_bad_o = bad_q || lost_i;
`endif

endmodule

// File: rtl/fix_rx_framer.sv
// Byte buffer releasing only complete FIX messages; first byte readable one cycle after the
// final SOH. ready_o drops when full; lost bytes poison the message, which is rolled back.
module fix_rx_framer
  import fix_rx_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [7:0]       message_i,
  output logic             ready_o,
  output logic             new_message_o,
  input  logic             rd_en_i,
  output logic             valid_o,
  output logic [7:0]       message_o,
  output logic             eom_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] msg_count_o
);

  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [8:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      commit_ptr_q, commit_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] msg_count_q, msg_count_d;
  logic             drop_q, drop_d;

  logic       full, wr_en, lost;
  logic       eom_pulse, msg_bad, commit;
  logic       rd_fire, rd_eom;
  logic [8:0] rd_word;

  assign full  = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign wr_en = valid_i && !full;
  assign lost  = valid_i && full;

  fix_tag_parser u_parser (
    .clk         (clk),
    .rst         (rst),
    .vld_i       (valid_i),
    .byte_i      (message_i),
    .lost_i      (lost),
    .eom_pulse_o (eom_pulse),
    .msg_bad_o   (msg_bad)
  );

  assign commit  = eom_pulse && !msg_bad;
  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_fire = rd_en_i && valid_o;
  assign rd_eom  = rd_fire && rd_word[8];

  assign ready_o       = !full;
  assign valid_o       = rd_ptr_q != commit_ptr_q;
  assign message_o     = rd_word[7:0];
  assign eom_o         = valid_o && rd_word[8];
  assign drop_o        = drop_q;
  assign msg_count_o   = msg_count_q;
  assign new_message_o = msg_count_q != '0;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    msg_count_d  = msg_count_q;
    drop_d       = 1'b0;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (eom_pulse) begin
      if (msg_bad) begin
        wr_ptr_d = commit_ptr_q;
        drop_d   = 1'b1;
      end else begin
        commit_ptr_d = wr_ptr_d;
      end
    end
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    if (commit && !rd_eom)      msg_count_d = msg_count_q + 1'b1;
    else if (!commit && rd_eom) msg_count_d = msg_count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      msg_count_q  <= '0;
      drop_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      msg_count_q  <= msg_count_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {eom_pulse, message_i};
  end

endmodule

// File: tb/tb_fix_rx_framer.sv
// Randomized and directed bench for fix_rx_framer against a message-level reference model.
module tb_fix_rx_framer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam logic [7:0] SOH = 8'h01;
`ifdef FIX_RX_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef bit bitq_t[$];

  logic             clk = 1'b0;
  logic             rst, valid_i, rd_en_i;
  logic [7:0]       message_i;
  logic             ready_o, new_message_o, valid_o, eom_o, drop_o;
  logic [7:0]       message_o;
  logic [CNT_W-1:0] msg_count_o;

  int compared = 0;
  int mismatched = 0;
  int drop_seen = 0;

  fix_rx_framer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .message_i(message_i), .ready_o(ready_o),
    .new_message_o(new_message_o), .rd_en_i(rd_en_i), .valid_o(valid_o), .message_o(message_o),
    .eom_o(eom_o), .drop_o(drop_o), .msg_count_o(msg_count_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (drop_o === 1'b1) drop_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (message level) ----------------
  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back((s[i] == 8'h7C) ? SOH : s[i]);
    return q;
  endfunction

  function automatic int body_sum(input bq_t b);
    int s = 0;
    foreach (b[i]) s += b[i];
    return s % 256;
  endfunction

  function automatic bq_t with_trailer(input bq_t body, input int ck);
    bq_t m = body;
    m.push_back(8'h31); m.push_back(8'h30); m.push_back(8'h3D);
    m.push_back(8'(48 + ck / 100));
    m.push_back(8'(48 + (ck / 10) % 10));
    m.push_back(8'(48 + ck % 10));
    m.push_back(SOH);
    return m;
  endfunction

  function automatic bq_t gen_body(input int max_vl);
    bq_t b;
    int vl = $urandom_range(1, max_vl);
    b.push_back(($urandom_range(0, 1) == 0) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(50, 57)));
    b.push_back(8'h3D);
    for (int i = 0; i < vl; i++) b.push_back(8'($urandom_range(97, 122)));
    b.push_back(SOH);
    return b;
  endfunction

  // A message is kept iff it fits, ends in <SOH>10=ddd<SOH>, and (when enabled) ddd equals the body sum.
  function automatic bit model_good(input bq_t m, input int free_bytes);
    int n = m.size();
    int ck = 0;
    int s = 0;
    if (n < 7 || n > free_bytes) return 1'b0;
    if (m[n-1] != SOH || m[n-7] != 8'h31 || m[n-6] != 8'h30 || m[n-5] != 8'h3D) return 1'b0;
    if (n > 7 && m[n-8] != SOH) return 1'b0;
    for (int i = n - 4; i <= n - 2; i++) begin
      if (m[i] < 8'h30 || m[i] > 8'h39) return 1'b0;
      ck = ck * 10 + int'(m[i]) - 48;
    end
    for (int i = 0; i < n - 7; i++) s += m[i];
    return !CK_EN || (ck == s % 256);
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    return (a.size() == b.size()) ? -1 : n;
  endfunction

  function automatic bit eom_only_last(input bitq_t e);
    foreach (e[i]) if (e[i] != (i == e.size() - 1)) return 1'b0;
    return e.size() > 0;
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid_i = 1'b1;
    message_i = b;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send_msg(input bq_t m);
    foreach (m[i]) send_byte(m[i]);
  endtask

  task automatic drain(output bq_t data, output bitq_t eoms, input int limit);
    data = {};
    eoms = {};
    rd_en_i = 1'b1;
    for (int i = 0; i < limit && valid_o === 1'b1; i++) begin
      data.push_back(message_o);
      eoms.push_back(eom_o);
      tick();
    end
    rd_en_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; rd_en_i = 1'b0; message_i = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    compared++;
    if ({ready_o, new_message_o, valid_o, eom_o, drop_o} !== 5'b10000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 10000", {ready_o, new_message_o, valid_o, eom_o, drop_o});
    end
    compared++;
    if (msg_count_o !== '0) begin
      mismatched++;
      $display("FAIL reset_count: got %0d expected 0", msg_count_o);
    end
  endtask

  task automatic test_good_msg();
    bq_t m = str2q("8=A|10=183|");
    bq_t got;
    bitq_t geo;
    bit exp_good = model_good(m, DEPTH);
    send_msg(m);
    compared++;
    if (new_message_o !== exp_good || msg_count_o !== CNT_W'(exp_good)) begin
      mismatched++;
      $display("FAIL good_commit: new=%b count=%0d expected new=%b count=%0d", new_message_o, msg_count_o, exp_good, exp_good);
    end
    compared++;
    if (valid_o !== 1'b1 || message_o !== m[0]) begin
      mismatched++;
      $display("FAIL good_first_byte: valid=%b byte=%h expected valid=1 byte=%h", valid_o, message_o, m[0]);
    end
    drain(got, geo, 40);
    compared++;
    if (first_diff(got, m) != -1 || !eom_only_last(geo)) begin
      mismatched++;
      $display("FAIL good_data: got %0d bytes diff@%0d eom_ok=%0b expected %0d bytes eom on last only", got.size(), first_diff(got, m), eom_only_last(geo), m.size());
    end
    compared++;
    if (new_message_o !== 1'b0 || valid_o !== 1'b0 || msg_count_o !== '0) begin
      mismatched++;
      $display("FAIL good_after_read: new=%b valid=%b count=%0d expected 0 0 0", new_message_o, valid_o, msg_count_o);
    end
  endtask

  task automatic test_bad_checksum();
    bq_t m = str2q("8=A|10=184|");
    bq_t got;
    bq_t expq;
    bitq_t geo;
    bit exp_good = model_good(m, DEPTH);
    int d0 = drop_seen;
    if (exp_good) expq = m;
    send_msg(m);
    compared++;
    if (drop_o !== !exp_good || valid_o !== exp_good) begin
      mismatched++;
      $display("FAIL badck_end: drop=%b valid=%b expected drop=%b valid=%b", drop_o, valid_o, !exp_good, exp_good);
    end
    tick();
    compared++;
    if (drop_o !== 1'b0) begin
      mismatched++;
      $display("FAIL badck_pulse: drop=%b expected 0 one cycle later", drop_o);
    end
    tick();
    compared++;
    if (drop_seen - d0 != int'(!exp_good)) begin
      mismatched++;
      $display("FAIL badck_drop_count: got %0d expected %0d", drop_seen - d0, int'(!exp_good));
    end
    drain(got, geo, 40);
    compared++;
    if (first_diff(got, expq) != -1 || (exp_good && !eom_only_last(geo))) begin
      mismatched++;
      $display("FAIL badck_data: got %0d bytes expected %0d", got.size(), expq.size());
    end
  endtask

  task automatic test_malformed();
    bq_t bad = str2q("8=A|10=1X3|");
    bq_t body = str2q("9=QZ|");
    bq_t good = with_trailer(body, body_sum(body));
    bq_t got;
    bitq_t geo;
    int d0 = drop_seen;
    send_msg(bad);
    compared++;
    if (valid_o !== 1'b0 || drop_seen != d0) begin
      mismatched++;
      $display("FAIL malformed_hold: valid=%b drops=%0d expected valid=0 drops=0", valid_o, drop_seen - d0);
    end
    send_msg(str2q("10=000|"));
    compared++;
    if (drop_o !== 1'b1 || valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL malformed_drop: drop=%b valid=%b expected drop=1 valid=0", drop_o, valid_o);
    end
    send_msg(good);
    drain(got, geo, 40);
    compared++;
    if (first_diff(got, good) != -1 || !eom_only_last(geo)) begin
      mismatched++;
      $display("FAIL malformed_next_msg: got %0d bytes diff@%0d expected %0d bytes", got.size(), first_diff(got, good), good.size());
    end
  endtask

  task automatic test_overflow();
    bq_t body = str2q("8=ABCDEFGHIJ|");
    bq_t m = with_trailer(body, body_sum(body));
    bit exp_good = model_good(m, DEPTH);
    foreach (m[i]) begin
      send_byte(m[i]);
      if (i == DEPTH - 2 || i == DEPTH - 1) begin
        compared++;
        if (ready_o !== (i == DEPTH - 2)) begin
          mismatched++;
          $display("FAIL overflow_ready_after_%0d: got %b expected %b", i + 1, ready_o, i == DEPTH - 2);
        end
      end
    end
    compared++;
    if (drop_o !== !exp_good) begin
      mismatched++;
      $display("FAIL overflow_drop: got %b expected %b", drop_o, !exp_good);
    end
    tick();
    compared++;
    if ({ready_o, valid_o, new_message_o} !== 3'b100 || msg_count_o !== '0) begin
      mismatched++;
      $display("FAIL overflow_empty: ready/valid/new=%b count=%0d expected 100 count 0", {ready_o, valid_o, new_message_o}, msg_count_o);
    end
  endtask

  task automatic test_back_to_back();
    bq_t ba = gen_body(1);
    bq_t bb = gen_body(1);
    bq_t a = with_trailer(ba, body_sum(ba));
    bq_t b = with_trailer(bb, body_sum(bb));
    bq_t got;
    bitq_t geo;
    send_msg(a);
    compared++;
    if (msg_count_o !== CNT_W'(1)) begin
      mismatched++;
      $display("FAIL b2b_first_commit: count=%0d expected 1", msg_count_o);
    end
    foreach (b[i]) begin
      valid_i = 1'b1; message_i = b[i]; rd_en_i = 1'b1;
      compared++;
      if (message_o !== a[i] || eom_o !== (i == a.size() - 1)) begin
        mismatched++;
        $display("FAIL b2b_read_%0d: byte=%h eom=%b expected byte=%h eom=%b", i, message_o, eom_o, a[i], i == a.size() - 1);
      end
      tick();
      compared++;
      if (msg_count_o !== CNT_W'(1)) begin
        mismatched++;
        $display("FAIL b2b_count_%0d: count=%0d expected 1", i, msg_count_o);
      end
    end
    valid_i = 1'b0; rd_en_i = 1'b0;
    drain(got, geo, 40);
    compared++;
    if (first_diff(got, b) != -1 || !eom_only_last(geo)) begin
      mismatched++;
      $display("FAIL b2b_second_data: got %0d bytes diff@%0d expected %0d bytes", got.size(), first_diff(got, b), b.size());
    end
  endtask

  task automatic test_reset_mid();
    bq_t bc = gen_body(1);
    bq_t bd = gen_body(6);
    bq_t be = gen_body(6);
    bq_t c = with_trailer(bc, body_sum(bc));
    bq_t d = with_trailer(bd, body_sum(bd));
    bq_t e = with_trailer(be, body_sum(be));
    bq_t got;
    bitq_t geo;
    send_msg(c);
    for (int i = 0; i < 5; i++) send_byte(d[i]);
    compared++;
    if (new_message_o !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pre: new=%b expected 1", new_message_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if ({ready_o, new_message_o, valid_o, eom_o, drop_o} !== 5'b10000 || msg_count_o !== '0) begin
      mismatched++;
      $display("FAIL rstmid_state: flags=%b count=%0d expected 10000 count 0", {ready_o, new_message_o, valid_o, eom_o, drop_o}, msg_count_o);
    end
    send_msg(e);
    drain(got, geo, 40);
    compared++;
    if (first_diff(got, e) != -1 || !eom_only_last(geo)) begin
      mismatched++;
      $display("FAIL rstmid_next_msg: got %0d bytes diff@%0d expected %0d bytes", got.size(), first_diff(got, e), e.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bq_t body = gen_body(6);
      bq_t m;
      bq_t got;
      bq_t expq;
      bitq_t geo;
      int s = body_sum(body);
      int mode = $urandom_range(0, 2);
      int ck = (mode == 0) ? s : (mode == 1) ? (s + 1 + $urandom_range(0, 254)) % 256 : s + 256;
      bit exp_good;
      m = with_trailer(body, ck);
      exp_good = model_good(m, DEPTH);
      if (exp_good) expq = m;
      foreach (m[i]) begin
        repeat ($urandom_range(0, 2)) begin
          rd_en_i = 1'($urandom_range(0, 1));
          tick();
        end
        rd_en_i = 1'($urandom_range(0, 1));
        send_byte(m[i]);
        if (i == m.size() - 2) begin
          compared++;
          if (valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rand%0d_early_valid: valid=%b expected 0 before final SOH", n, valid_o);
          end
        end
      end
      rd_en_i = 1'b0;
      compared++;
      if (drop_o !== !exp_good || msg_count_o !== CNT_W'(exp_good)) begin
        mismatched++;
        $display("FAIL rand%0d_end: drop=%b count=%0d expected drop=%b count=%0d", n, drop_o, msg_count_o, !exp_good, exp_good);
      end
      drain(got, geo, 40);
      compared++;
      if (first_diff(got, expq) != -1 || (exp_good && !eom_only_last(geo))) begin
        mismatched++;
        $display("FAIL rand%0d_data: got %0d bytes diff@%0d expected %0d bytes", n, got.size(), first_diff(got, expq), expq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_msg();
    test_bad_checksum();
    test_malformed();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
